ram_1w_1rs_arbiter: RTL and testbench

//  Shares one Ram_1w_1rs instance (1 write port, 1 sync read port, same clock) between NUM_REQ requesters.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/ram_1w_1rs_arbiter.sv | 106 ++++++++++
 tb/tb_ram_1w_1rs_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and round-robin pick helper for the RAM arbiter
package ram_arb_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {IDLE, CLEAR} arb_state_e;
  // Bits of req at or above the real requester count are zero, so scanning modulo MAX_REQ
  // finds the same winner as scanning modulo the real count.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr);
    logic [MAX_REQ-1:0] g;
    logic found;
    logic [2:0] idx;
    g = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with a pointer that moves past the winner when advance is set
module rr_arbiter import ram_arb_pkg::*; #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  logic [2:0] ptr_q, ptr_d, idx;
  logic [MAX_REQ-1:0] pick;
  logic unused_pick;
  assign pick = rr_pick(MAX_REQ'(req), ptr_q);
  assign gnt = pick[N-1:0];
  assign unused_pick = ^pick;
  // next pointer is one past the granted index, wrapping at N
  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) idx = gnt[k] ? 3'(k) : idx;
    ptr_d = (advance && |gnt) ? ((idx == 3'(N - 1)) ? 3'd0 : idx + 3'd1) : ptr_q;
  end
  // pointer register, requester 0 first after reset
  always_ff @(posedge clk) ptr_q <= !rst_n ? 3'd0 : ptr_d;
endmodule

// File: rtl/ram_1w_1rs_arbiter.sv
// ram_1w_1rs_arbiter: shares a 1W/1R sync RAM among requesters with a zero-fill sequencer; RAM_ARB_PERF_EN adds stall_cnt
module ram_1w_1rs_arbiter import ram_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        wr_valid,
  output logic [NUM_REQ-1:0]        wr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  input  logic [NUM_REQ*MASK_W-1:0] wr_mask,
  input  logic [NUM_REQ-1:0]        rd_valid,
  output logic [NUM_REQ-1:0]        rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      clr_start,
  output logic                      clr_busy,
`ifdef RAM_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]     stall_cnt,
`endif
  output logic                      ram_wr_en,
  output logic [MASK_W-1:0]         ram_wr_mask,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_wr_data,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_rd_data
);
  arb_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wa, ra;
  logic [NUM_REQ-1:0] rsp_q, wreq, rreq, wgnt, rgnt;
  logic [DATA_W-1:0] wd;
  logic [MASK_W-1:0] wm;
  logic open, clr, coll, rd_go;
  // requests only compete out of reset and outside a clear, so ram_* stay 0 in reset
  assign open = rst_n && state_q == IDLE;
  assign clr = rst_n && state_q == CLEAR;
  assign wreq = open ? wr_valid : '0;
  assign rreq = open ? rd_valid : '0;
  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (.clk(clk), .rst_n(rst_n), .req(wreq), .advance(1'b1), .gnt(wgnt));
  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (.clk(clk), .rst_n(rst_n), .req(rreq), .advance(!coll), .gnt(rgnt));
  // one-hot payload select for the granted writer and reader
  always_comb begin
    wa = '0;
    wd = '0;
    wm = '0;
    ra = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wa |= wgnt[i] ? wr_addr[i*ADDR_W +: ADDR_W] : '0;
      wd |= wgnt[i] ? wr_data[i*DATA_W +: DATA_W] : '0;
      wm |= wgnt[i] ? wr_mask[i*MASK_W +: MASK_W] : '0;
      ra |= rgnt[i] ? rd_addr[i*ADDR_W +: ADDR_W] : '0;
    end
  end
  // same-address read is held back one cycle since the RAM has no read-under-write rule
  assign coll = |wgnt && |rgnt && wa == ra;
  assign rd_go = |rgnt && !coll;
  assign wr_ready = wgnt;
  assign rd_ready = coll ? '0 : rgnt;
  assign ram_wr_en = clr || |wgnt;
  assign ram_wr_mask = clr ? '1 : wm;
  assign ram_wr_addr = clr ? cnt_q : wa;
  assign ram_wr_data = clr ? '0 : wd;
  assign ram_rd_en = rd_go;
  assign ram_rd_addr = rd_go ? ra : '0;
  assign rsp_valid = rsp_q;
  assign rsp_data = ram_rd_data;
  assign clr_busy = state_q == CLEAR;
  // clear walks every address once and returns to IDLE after the last one
  always_comb begin
    state_d = state_q == IDLE ? (clr_start ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d = state_q == CLEAR ? cnt_q + ADDR_W'(1) : '0;
  end
  // FSM, clear counter and response tag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_q <= rd_ready;
    end
  end
`ifdef RAM_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] stall_q, stall_d;
  logic [16:0] sum;
  // saturating per-requester count of stalled read and write requests
  always_comb begin
    stall_d = stall_q;
    sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, stall_q[i*16 +: 16]} + 17'(wr_valid[i] & ~wr_ready[i]) + 17'(rd_valid[i] & ~rd_ready[i]);
      stall_d[i*16 +: 16] = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
  // stall counter registers
  always_ff @(posedge clk) stall_q <= !rst_n ? '0 : stall_d;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_ram_1w_1rs_arbiter.sv
// tb_ram_1w_1rs_arbiter: vector table plus read-response scoreboard against a behavioural RAM
module tb_ram_1w_1rs_arbiter;
  localparam int N = 2, AW = 5, DW = 32, MW = 4, D = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;
  logic [N*MW-1:0] wr_mask;
  logic [DW-1:0] rsp_data, ram_wr_data, ram_rd_data;
  logic clr_start, clr_busy, ram_wr_en, ram_rd_en;
  logic [MW-1:0] ram_wr_mask;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
`ifdef RAM_ARB_PERF_EN
  logic [N*16-1:0] stall_cnt;
`endif

  ram_1w_1rs_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .clr_start(clr_start), .clr_busy(clr_busy),
`ifdef RAM_ARB_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data));

  // RAM macro model: byte lanes, registered read, known pattern loaded while in reset
  logic [DW-1:0] ram [D];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) ram[i] <= 32'h1000_0000 + i;
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en)
        for (int l = 0; l < MW; l++) if (ram_wr_mask[l]) ram[ram_wr_addr][l*8 +: 8] <= ram_wr_data[l*8 +: 8];
      if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    end
  end

  typedef struct {
    logic [1:0] wv; logic [4:0] wa0, wa1; logic [31:0] wd0, wd1; logic [3:0] wm;
    logic [1:0] rv; logic [4:0] ra0, ra1; logic [1:0] ewr, erd;
  } vec_t;
  typedef struct { logic [N-1:0] v; logic [DW-1:0] d; } rsp_t;

  vec_t vt [13];
  rsp_t sb [$];
  logic [DW-1:0] shadow [D];
  int n_vec = 0, n_bad = 0;

  function automatic vec_t mk(logic [1:0] wv, logic [4:0] wa0, wa1, logic [31:0] wd0, wd1, logic [3:0] wm,
                              logic [1:0] rv, logic [4:0] ra0, ra1, logic [1:0] ewr, erd);
    return '{wv, wa0, wa1, wd0, wd1, wm, rv, ra0, ra1, ewr, erd};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic shadow_init();
    for (int i = 0; i < D; i++) shadow[i] = 32'h1000_0000 + i;
  endtask

  // inputs already driven at the falling edge; check readies, book expected traffic, check response
  task automatic cycle(input logic [N-1:0] ewr, input logic [N-1:0] erd, input logic ebusy, input string nm);
    rsp_t r;
    #1;
    chk({nm, " wr_ready"}, 64'(wr_ready), 64'(ewr));
    chk({nm, " rd_ready"}, 64'(rd_ready), 64'(erd));
    chk({nm, " clr_busy"}, 64'(clr_busy), 64'(ebusy));
    for (int i = 0; i < N; i++) if (erd[i]) sb.push_back('{erd, shadow[rd_addr[i*AW +: AW]]});
    for (int i = 0; i < N; i++)
      if (ewr[i])
        for (int l = 0; l < MW; l++)
          if (wr_mask[i*MW + l]) shadow[wr_addr[i*AW +: AW]][l*8 +: 8] = wr_data[i*DW + l*8 +: 8];
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(r.v));
      chk({nm, " rsp_data"}, 64'(rsp_data), 64'(r.d));
    end else chk({nm, " rsp_idle"}, 64'(rsp_valid), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    vt[0]  = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b01, 5, 0, 2'b00, 2'b01);
    vt[1]  = mk(2'b11, 1, 2, 32'hA0A0_0001, 32'hB0B0_0002, 4'hF, 2'b00, 0, 0, 2'b01, 2'b00);
    vt[2]  = mk(2'b11, 1, 2, 32'hA0A0_0001, 32'hB0B0_0002, 4'hF, 2'b00, 0, 0, 2'b10, 2'b00);
    vt[3]  = mk(2'b11, 1, 2, 32'hA0A0_0001, 32'hB0B0_0002, 4'hF, 2'b00, 0, 0, 2'b01, 2'b00);
    vt[4]  = mk(2'b11, 1, 2, 32'hA0A0_0001, 32'hB0B0_0002, 4'hF, 2'b00, 0, 0, 2'b10, 2'b00);
    vt[5]  = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b11, 1, 2, 2'b00, 2'b10);
    vt[6]  = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b01, 1, 2, 2'b00, 2'b01);
    vt[7]  = mk(2'b01, 3, 0, 32'hC3C3_0003, 0, 4'hF, 2'b10, 0, 3, 2'b01, 2'b00);
    vt[8]  = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b11, 7, 3, 2'b00, 2'b10);
    vt[9]  = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b01, 7, 3, 2'b00, 2'b01);
    vt[10] = mk(2'b10, 0, 9, 0, 32'h1122_3344, 4'hF, 2'b00, 0, 0, 2'b10, 2'b00);
    vt[11] = mk(2'b01, 9, 0, 32'hAABB_CCDD, 0, 4'b0100, 2'b00, 0, 0, 2'b01, 2'b00);
    vt[12] = mk(2'b00, 0, 0, 0, 0, 4'hF, 2'b01, 9, 0, 2'b00, 2'b01);
    shadow_init();
    clr_start = 1'b0;
    wr_valid = 2'b11; rd_valid = 2'b11;
    wr_addr = {5'd2, 5'd1}; rd_addr = {5'd2, 5'd1};
    wr_data = '0; wr_mask = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ram_wr_en", 64'(ram_wr_en), 64'(0));
    chk("reset ram_rd_en", 64'(ram_rd_en), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset clr_busy", 64'(clr_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wr_valid = vt[i].wv; wr_addr = {vt[i].wa1, vt[i].wa0}; wr_data = {vt[i].wd1, vt[i].wd0};
      wr_mask = {2{vt[i].wm}}; rd_valid = vt[i].rv; rd_addr = {vt[i].ra1, vt[i].ra0};
      cycle(vt[i].ewr, vt[i].erd, 1'b0, $sformatf("v%0d", i));
    end
    chk("masked word", 64'(shadow[9]), 64'(32'h11BB_3344));
    // clear with a read accepted in the entry cycle and a stray clr_start mid-clear
    wr_valid = 2'b00; rd_valid = 2'b01; rd_addr = {5'd0, 5'd9}; clr_start = 1'b1;
    cycle(2'b00, 2'b01, 1'b0, "clr_entry");
    for (int i = 0; i < D; i++) shadow[i] = '0;
    for (int k = 0; k < D; k++) begin
      clr_start = (k == 20);
      wr_valid = k < D - 1 ? 2'b11 : 2'b00; rd_valid = wr_valid;
      wr_addr = {5'd4, 5'd3}; rd_addr = {5'd6, 5'd5}; wr_data = '1;
      #1;
      chk($sformatf("clr%0d addr", k), 64'(ram_wr_addr), 64'(k));
      chk($sformatf("clr%0d en", k), 64'({ram_wr_en, ram_rd_en}), 64'(2'b10));
      chk($sformatf("clr%0d data", k), 64'({ram_wr_mask, ram_wr_data}), 64'({4'hF, 32'h0}));
      cycle(2'b00, 2'b00, 1'b1, $sformatf("clr%0d", k));
    end
    clr_start = 1'b0;
    for (int k = 0; k < D; k++) begin
      wr_valid = 2'b00; rd_valid = 2'b01; rd_addr = {5'd0, 5'(k)};
      cycle(2'b00, 2'b01, 1'b0, $sformatf("zero%0d", k));
    end
    // reset in the middle of a clear
    rd_valid = 2'b00; clr_start = 1'b1;
    cycle(2'b00, 2'b00, 1'b0, "clr2_entry");
    clr_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wr_valid = 2'b11; rd_valid = 2'b11;
      cycle(2'b00, 2'b00, 1'b1, $sformatf("clr2_%0d", k));
    end
    rst_n = 1'b0; wr_valid = 2'b00; rd_valid = 2'b00;
    @(posedge clk);
    #1;
    chk("abort clr_busy", 64'(clr_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    shadow_init();
    wr_valid = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'h0, 32'h5555_0002}; wr_mask = '1;
    rd_valid = 2'b11; rd_addr = {5'd7, 5'd6};
    cycle(2'b01, 2'b01, 1'b0, "post_abort");
    wr_valid = 2'b00; rd_valid = 2'b01; rd_addr = {5'd0, 5'd2};
    cycle(2'b00, 2'b01, 1'b0, "post_abort_rd");
    rd_valid = 2'b00;
    cycle(2'b00, 2'b00, 1'b0, "drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
